// File: rtl/affine_pkg.sv
// Shared constants for the horizontal 6-tap affine interpolator:
// the coefficient table, row-width decode and controller states.
package affine_pkg;

  localparam int CW   = 8;
  localparam int NTAP = 6;
  localparam int NPH  = 16;

  localparam int W4  = 4;
  localparam int W8  = 8;
  localparam int W16 = 16;

  typedef logic signed [CW-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Row index is the 1/16-pel phase; every row sums to 64.
  localparam coef_t COEF [NPH][NTAP] = '{
    '{ 8'sd0,  8'sd0,  8'sd64, 8'sd0,  8'sd0,  8'sd0 },
    '{ 8'sd1, -8'sd3,  8'sd63, 8'sd4, -8'sd2,  8'sd1 },
    '{ 8'sd1, -8'sd5,  8'sd62, 8'sd8, -8'sd3,  8'sd1 },
    '{ 8'sd2, -8'sd8,  8'sd60, 8'sd13, -8'sd4,  8'sd1 },
    '{ 8'sd3, -8'sd10, 8'sd58, 8'sd17, -8'sd5,  8'sd1 },
    '{ 8'sd3, -8'sd11, 8'sd52, 8'sd26, -8'sd8,  8'sd2 },
    '{ 8'sd2, -8'sd9,  8'sd47, 8'sd31, -8'sd10, 8'sd3 },
    '{ 8'sd3, -8'sd10, 8'sd45, 8'sd34, -8'sd12, 8'sd4 },
    '{ 8'sd3, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd3 },
    '{ 8'sd4, -8'sd12, 8'sd34, 8'sd45, -8'sd10, 8'sd3 },
    '{ 8'sd3, -8'sd10, 8'sd31, 8'sd47, -8'sd9,  8'sd2 },
    '{ 8'sd2, -8'sd8,  8'sd26, 8'sd52, -8'sd11, 8'sd3 },
    '{ 8'sd1, -8'sd5,  8'sd17, 8'sd58, -8'sd10, 8'sd3 },
    '{ 8'sd1, -8'sd4,  8'sd13, 8'sd60, -8'sd8,  8'sd2 },
    '{ 8'sd1, -8'sd3,  8'sd8,  8'sd62, -8'sd5,  8'sd1 },
    '{ 8'sd1, -8'sd2,  8'sd4,  8'sd63, -8'sd3,  8'sd1 }
  };

  function automatic logic [4:0] wlen_decode(input logic [1:0] wsel);
    case (wsel)
      2'd0:    return 5'(W4);
      2'd1:    return 5'(W8);
      default: return 5'(W16);
    endcase
  endfunction

endpackage

// File: rtl/affine_hfilt_dp.sv
// Sample window, per-tap constant multipliers, phase select and adder tree.
// The sum reflects the window as it stands after this cycle's shift.
module affine_hfilt_dp
  import affine_pkg::*;
#(
  parameter int IN_SIZE  = 8,
  parameter int OUT_SIZE = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift_en,
  input  logic signed [IN_SIZE-1:0]  in_data,
  input  logic        [3:0]          frac,
  output logic signed [OUT_SIZE-1:0] sum
);

  localparam int PW = IN_SIZE + CW;

  logic signed [IN_SIZE-1:0]  win_q [NTAP];
  logic signed [IN_SIZE-1:0]  win_d [NTAP];
  logic signed [PW-1:0]       prod  [NTAP][NPH];
  logic signed [OUT_SIZE-1:0] sel   [NTAP];
  logic signed [OUT_SIZE-1:0] s01, s23, s45;

  always_comb begin
    for (int k = 0; k < NTAP; k++) win_d[k] = win_q[k];
    if (shift_en) begin
      for (int k = 0; k < NTAP-1; k++) win_d[k] = win_q[k+1];
      win_d[NTAP-1] = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAP; k++) win_q[k] <= '0;
    end else begin
      for (int k = 0; k < NTAP; k++) win_q[k] <= win_d[k];
    end
  end

  // Each tap forms all sixteen phase products of its sample; frac picks one.
  for (genvar k = 0; k < NTAP; k++) begin : g_tap
    for (genvar f = 0; f < NPH; f++) begin : g_ph
      assign prod[k][f] = PW'(win_d[k]) * PW'(COEF[f][k]);
    end
    assign sel[k] = OUT_SIZE'(prod[k][frac]);
  end

  assign s01 = sel[0] + sel[1];
  assign s23 = sel[2] + sel[3];
  assign s45 = sel[4] + sel[5];
  assign sum = s01 + s23 + s45;

endmodule

// File: rtl/affine_hfilt_ctrl.sv
// Sequences one horizontal 6-tap affine pass over a 4/8/16-wide output row:
// FSM, sample counting, phase latch and the registered valid/ready output.
module affine_hfilt_ctrl
  import affine_pkg::*;
#(
  parameter int IN_SIZE  = 8,
  parameter int OUT_SIZE = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic        [3:0]          frac,
  input  logic        [1:0]          wsel,
  output logic                       busy,
  output logic                       done,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_SIZE-1:0]  in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_SIZE-1:0] out_data,
  output logic                       out_last
);

  state_e                     state_q, state_d;
  logic [3:0]                 frac_q, frac_d;
  logic [4:0]                 wlen_q, wlen_d;
  logic [4:0]                 cnt_q, cnt_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;
  logic                       done_q, done_d;
  logic signed [OUT_SIZE-1:0] out_data_q, out_data_d;
  logic signed [OUT_SIZE-1:0] sum;
  logic                       adv, accept, last_in, out_hs;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = ((state_q == LOAD) || (state_q == RUN)) && adv;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;
  assign last_in  = (cnt_q == (wlen_q + 5'd4));

  affine_hfilt_dp #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .in_data  (in_data),
    .frac     (frac_q),
    .sum      (sum)
  );

  always_comb begin
    state_d     = state_q;
    frac_d      = frac_q;
    wlen_d      = wlen_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    // A RUN accept below overrides this, giving back-to-back results.
    if (out_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          frac_d  = frac;
          wlen_d  = wlen_decode(wsel);
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd4) state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d       = cnt_q + 5'd1;
          out_valid_d = 1'b1;
          out_last_d  = last_in;
          out_data_d  = sum;
          if (last_in) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      frac_q      <= '0;
      wlen_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frac_q      <= frac_d;
      wlen_q      <= wlen_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_affine_hfilt_ctrl.sv
// Bench for affine_hfilt_ctrl: directed and randomized rows checked against a
// plain convolution model of the interpolation filter.
module tb_affine_hfilt_ctrl;

  logic              clk = 1'b0;
  logic              rst, start, busy, done;
  logic [3:0]        frac;
  logic [1:0]        wsel;
  logic              in_valid, in_ready, out_valid, out_ready, out_last;
  logic signed [7:0] in_data;
  logic signed [15:0] out_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  affine_hfilt_ctrl #(.IN_SIZE(8), .OUT_SIZE(16)) dut (
    .clk(clk), .rst(rst), .start(start), .frac(frac), .wsel(wsel),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  int C [16][6] = '{
    '{0, 0, 64, 0, 0, 0},    '{1, -3, 63, 4, -2, 1},   '{1, -5, 62, 8, -3, 1},
    '{2, -8, 60, 13, -4, 1}, '{3, -10, 58, 17, -5, 1}, '{3, -11, 52, 26, -8, 2},
    '{2, -9, 47, 31, -10, 3},'{3, -10, 45, 34, -12, 4},'{3, -11, 40, 40, -11, 3},
    '{4, -12, 34, 45, -10, 3},'{3, -10, 31, 47, -9, 2},'{2, -8, 26, 52, -11, 3},
    '{1, -5, 17, 58, -10, 3},'{1, -4, 13, 60, -8, 2},  '{1, -3, 8, 62, -5, 1},
    '{1, -2, 4, 63, -3, 1}
  };

  int stim[$];
  int expq[$];
  int got[$];
  bit got_last[$];
  int got_cyc[$];
  int acc_cyc[$];
  bit t_ov[$], t_ir[$], t_or[$], t_busy[$];
  int t_od[$];
  int done_cyc, n_done;
  bit timed_out;

  function automatic int wlen(input int ws);
    return (ws == 0) ? 4 : ((ws == 1) ? 8 : 16);
  endfunction

  function automatic void build_model(input int fr, input int w);
    expq.delete();
    for (int i = 0; i < w; i++) begin
      int s;
      s = 0;
      for (int k = 0; k < 6; k++) s += C[fr][k] * stim[i+k];
      expq.push_back(s);
    end
  endfunction

  task automatic set_ramp(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(i);
  endtask

  task automatic set_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(int'($urandom_range(255)) - 128);
  endtask

  // Drives one row and records handshakes and a per-cycle trace; no judging here.
  task automatic drive_row(input int fr, input int ws, input int gap_pct, input int stall_pct,
                           input int stall_after, input int stall_len, input int mid_start,
                           input int stop_outs, input bit skip_start, input bit chain,
                           input int chain_fr, input int chain_ws);
    int ptr;
    int stall_left;
    bit stall_used;
    ptr = 0; stall_left = 0; stall_used = 0;
    got.delete(); got_last.delete(); got_cyc.delete(); acc_cyc.delete();
    t_ov.delete(); t_ir.delete(); t_or.delete(); t_busy.delete(); t_od.delete();
    done_cyc = -1; n_done = 0; timed_out = 1;
    if (!skip_start) begin
      @(negedge clk);
      start = 1'b1; frac = 4'(fr); wsel = 2'(ws);
      in_valid = 1'b0; out_ready = 1'b1;
    end
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      start = 1'b0; frac = 4'($urandom); wsel = 2'($urandom);
      if (c == mid_start) begin start = 1'b1; frac = 4'd5; end
      if (chain && done) begin start = 1'b1; frac = 4'(chain_fr); wsel = 2'(chain_ws); end
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = (ptr < stim.size()) ? 8'(stim[ptr]) : 8'($urandom);
      if (stall_left == 0 && !stall_used && stall_len > 0 && got.size() == stall_after) begin
        stall_left = stall_len; stall_used = 1'b1;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0; stall_left--;
      end else begin
        out_ready = ($urandom_range(99) >= stall_pct);
      end
      #1;
      t_ov.push_back(out_valid); t_ir.push_back(in_ready); t_or.push_back(out_ready);
      t_busy.push_back(busy); t_od.push_back(int'(out_data));
      if (done) begin n_done++; if (done_cyc < 0) done_cyc = c; end
      if (in_valid && in_ready) begin acc_cyc.push_back(c); ptr++; end
      if (out_valid && out_ready) begin
        got.push_back(int'(out_data)); got_last.push_back(out_last); got_cyc.push_back(c);
      end
      if (done || (stop_outs > 0 && got.size() == stop_outs)) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0)  begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (out_data !== 16'sd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int ref_q [4] = '{128, 192, 256, 320};
    set_ramp(9);
    drive_row(0, 0, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%0d exp=0", timed_out); end
    checks++; if (got.size() !== 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] !== ref_q[i]) begin failures++; $display("FAIL basic_data[%0d] got=%0d exp=%0d", i, got[i], ref_q[i]); end
      checks++; if (got_last[i] !== (i == 3)) begin failures++; $display("FAIL basic_last[%0d] got=%0d exp=%0d", i, got_last[i], (i == 3)); end
      checks++; if (got_cyc[i] !== got_cyc[0] + i) begin failures++; $display("FAIL basic_gap[%0d] got=%0d exp=%0d", i, got_cyc[i], got_cyc[0] + i); end
    end
    checks++; if (acc_cyc.size() !== 9) begin failures++; $display("FAIL basic_accepts got=%0d exp=9", acc_cyc.size()); end
    if (acc_cyc.size() > 5 && got.size() > 0) begin
      checks++; if (got_cyc[0] !== acc_cyc[5] + 1) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", got_cyc[0], acc_cyc[5] + 1); end
    end
    if (got.size() > 0) begin
      checks++; if (done_cyc !== got_cyc[got.size()-1] + 1) begin failures++; $display("FAIL basic_done_cyc got=%0d exp=%0d", done_cyc, got_cyc[got.size()-1] + 1); end
    end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
    if (done_cyc >= 0) begin
      checks++; if (t_busy[done_cyc] !== 1'b0) begin failures++; $display("FAIL basic_busy_in_done got=%0d exp=0", t_busy[done_cyc]); end
    end
  endtask

  task automatic test_dc;
    int high;
    stim.delete();
    for (int i = 0; i < 13; i++) stim.push_back(-7);
    drive_row(8, 1, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0);
    checks++; if (got.size() !== 8) begin failures++; $display("FAIL dc_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== -448) begin failures++; $display("FAIL dc_data[%0d] got=%0d exp=-448", i, got[i]); end
    end
    checks++; if (acc_cyc.size() !== 13) begin failures++; $display("FAIL dc_accepts got=%0d exp=13", acc_cyc.size()); end
    if (acc_cyc.size() > 0) begin
      high = 0;
      for (int c = acc_cyc[acc_cyc.size()-1] + 1; c < t_ir.size(); c++) if (t_ir[c]) high++;
      checks++; if (high !== 0) begin failures++; $display("FAIL dc_in_ready_after_last got=%0d exp=0", high); end
    end
  endtask

  task automatic test_impulse;
    int fr_t [3]  = '{8, 15, 15};
    int val_t [3] = '{1, 1, -128};
    int exp_t [3] = '{40, 63, -8064};
    for (int t = 0; t < 3; t++) begin
      stim.delete();
      for (int i = 0; i < 9; i++) stim.push_back((i == 3) ? val_t[t] : 0);
      build_model(fr_t[t], 4);
      drive_row(fr_t[t], 0, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0);
      checks++; if (got.size() !== 4) begin failures++; $display("FAIL impulse%0d_count got=%0d exp=4", t, got.size()); end
      if (got.size() > 0) begin
        checks++; if (got[0] !== exp_t[t]) begin failures++; $display("FAIL impulse%0d_out0 got=%0d exp=%0d", t, got[0], exp_t[t]); end
      end
      for (int i = 1; i < got.size() && i < 4; i++) begin
        checks++; if (got[i] !== expq[i]) begin failures++; $display("FAIL impulse%0d_out%0d got=%0d exp=%0d", t, i, got[i], expq[i]); end
      end
    end
  endtask

  task automatic test_backpressure;
    int ref_q [4] = '{128, 192, 256, 320};
    int stalled, bad;
    set_ramp(9);
    drive_row(0, 0, 0, 0, 1, 3, -1, 0, 0, 0, 0, 0);
    checks++; if (got.size() !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] !== ref_q[i]) begin failures++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, got[i], ref_q[i]); end
    end
    stalled = 0; bad = 0;
    for (int c = 0; c < t_ov.size(); c++) begin
      if (t_ov[c] && !t_or[c]) begin
        stalled++;
        if (t_od[c] != 192 || t_ir[c]) bad++;
      end
    end
    checks++; if (stalled !== 3) begin failures++; $display("FAIL bp_stall_cycles got=%0d exp=3", stalled); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold_violations got=%0d exp=0", bad); end
    checks++; if (acc_cyc.size() !== 9) begin failures++; $display("FAIL bp_accepts got=%0d exp=9", acc_cyc.size()); end
  endtask

  task automatic test_busy_start;
    int fr, cfr;
    fr  = 1 + int'($urandom_range(14));
    if (fr == 5) fr = 6;
    cfr = int'($urandom_range(15));
    set_random(13);
    build_model(fr, 8);
    drive_row(fr, 1, 20, 20, 0, 0, 8, 0, 0, 1, cfr, 0);
    checks++; if (got.size() !== 8) begin failures++; $display("FAIL busy_start_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++; if (got[i] !== expq[i]) begin failures++; $display("FAIL busy_start_data[%0d] got=%0d exp=%0d", i, got[i], expq[i]); end
    end
    set_random(9);
    build_model(cfr, 4);
    drive_row(cfr, 0, 0, 0, 0, 0, -1, 0, 1, 0, 0, 0);
    checks++; if (t_busy.size() > 0 && t_busy[0] !== 1'b1) begin failures++; $display("FAIL chain_busy got=%0d exp=1", t_busy[0]); end
    checks++; if (got.size() !== 4) begin failures++; $display("FAIL chain_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] !== expq[i]) begin failures++; $display("FAIL chain_data[%0d] got=%0d exp=%0d", i, got[i], expq[i]); end
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      int fr, ws, w;
      fr = int'($urandom_range(15));
      ws = int'($urandom_range(3));
      w  = wlen(ws);
      set_random(w + 5);
      build_model(fr, w);
      drive_row(fr, ws, 30, 30, 0, 0, -1, 0, 0, 0, 0, 0);
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL rand%0d_timeout got=%0d exp=0", r, timed_out); end
      checks++; if (got.size() !== w) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, got.size(), w); end
      checks++; if (acc_cyc.size() !== w + 5) begin failures++; $display("FAIL rand%0d_accepts got=%0d exp=%0d", r, acc_cyc.size(), w + 5); end
      for (int i = 0; i < got.size() && i < w; i++) begin
        checks++; if (got[i] !== expq[i]) begin failures++; $display("FAIL rand%0d_data[%0d] got=%0d exp=%0d", r, i, got[i], expq[i]); end
        checks++; if (got_last[i] !== (i == w - 1)) begin failures++; $display("FAIL rand%0d_last[%0d] got=%0d exp=%0d", r, i, got_last[i], (i == w - 1)); end
      end
      if (got.size() > 0) begin
        checks++; if (done_cyc !== got_cyc[got.size()-1] + 1) begin failures++; $display("FAIL rand%0d_done_cyc got=%0d exp=%0d", r, done_cyc, got_cyc[got.size()-1] + 1); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int ref_q [4] = '{128, 192, 256, 320};
    set_ramp(9);
    drive_row(0, 0, 0, 0, 0, 0, -1, 2, 0, 0, 0, 0);
    checks++; if (got.size() !== 2) begin failures++; $display("FAIL rmid_outs got=%0d exp=2", got.size()); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre_valid got=%b exp=1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'sd0) begin failures++; $display("FAIL rmid_out_data got=%0d exp=0", out_data); end
    checks++; if (in_ready !== 1'b0)   begin failures++; $display("FAIL rmid_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_last !== 1'b0)   begin failures++; $display("FAIL rmid_out_last got=%b exp=0", out_last); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    drive_row(0, 0, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0);
    checks++; if (got.size() !== 4) begin failures++; $display("FAIL rmid_rerun_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] !== ref_q[i]) begin failures++; $display("FAIL rmid_rerun[%0d] got=%0d exp=%0d", i, got[i], ref_q[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; frac = 4'd0; wsel = 2'd0;
    in_valid = 1'b0; in_data = 8'sd0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_dc();
    test_impulse();
    test_backpressure();
    test_busy_start();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
